// File: rtl/window_vote_pkg.sv
// -----------------------------------------------------------------------------
// window_vote_pkg
// Shared definitions for the window vote filter and its popcount tree.
//   clog2p1(n)   : number of bits needed to hold the values 0..n
//   vote_state_t : filter state, OFF drives o=0, ON drives o=1
//   RISES_MAX    : saturation value of the rising-edge counter
// -----------------------------------------------------------------------------
package window_vote_pkg;

    // Width needed to represent every value from 0 up to and including n.
    function automatic int clog2p1(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'd1 << k) < 32'(n + 1)) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } vote_state_t;

    localparam logic [7:0] RISES_MAX = 8'd255;

endpackage

// File: rtl/popcount_tree.sv
// -----------------------------------------------------------------------------
// popcount_tree
// Combinational population count built as a balanced binary adder tree.
// The vector is split in halves, each half counted by a smaller instance of
// this module, and the two partial counts are added.
//   vec   in  N              vector to count
//   count out clog2p1(N)     number of set bits in vec
// -----------------------------------------------------------------------------
module popcount_tree
    import window_vote_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            vec,
    output logic [clog2p1(N)-1:0]   count
);

    localparam int CW = clog2p1(N);

    if (N == 1) begin : g_leaf
        // A single bit is its own count.
        assign count = vec;
    end else begin : g_node
        localparam int NL = N / 2;
        localparam int NH = N - NL;
        localparam int CL = clog2p1(NL);
        localparam int CH = clog2p1(NH);

        logic [CL-1:0] count_lo_s;
        logic [CH-1:0] count_hi_s;

        popcount_tree #(.N(NL)) u_lo (
            .vec   (vec[NL-1:0]),
            .count (count_lo_s)
        );

        popcount_tree #(.N(NH)) u_hi (
            .vec   (vec[N-1:NL]),
            .count (count_hi_s)
        );

        // Partial counts sum to at most N, so CW bits never overflow.
        assign count = CW'(count_lo_s) + CW'(count_hi_s);
    end

endmodule

// File: rtl/window_vote_filter.sv
// -----------------------------------------------------------------------------
// window_vote_filter
// Counts the set bits of a registered input vector and flags when the count
// lies in the runtime window [lo, hi]. The flag only changes after the window
// decision has disagreed with it for STABLE consecutive cycles, and every
// OFF->ON change of the flag is counted in a saturating 8-bit counter.
//   clk   in  1   clock, all state on the rising edge
//   rst   in  1   synchronous active-high reset
//   i     in  N   raw input vector
//   lo    in  CW  lower window bound, inclusive
//   hi    in  CW  upper window bound, inclusive
//   en    in  1   window enable; 0 forces the raw decision to 0
//   clr   in  1   clears the rising-edge counter
//   o     out 1   filtered window flag
//   cnt   out CW  registered popcount of the input
//   rises out 8   saturating count of o rising edges
// -----------------------------------------------------------------------------
module window_vote_filter
    import window_vote_pkg::*;
#(
    parameter int N      = 4,
    parameter int STABLE = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            i,
    input  logic [clog2p1(N)-1:0]   lo,
    input  logic [clog2p1(N)-1:0]   hi,
    input  logic                    en,
    input  logic                    clr,
    output logic                    o,
    output logic [clog2p1(N)-1:0]   cnt,
    output logic [7:0]              rises
);

    localparam int CW = clog2p1(N);
    localparam int RW = clog2p1(STABLE);
    localparam logic [RW-1:0] RUN_LAST = RW'(STABLE - 1);

    logic [N-1:0]   in_r;
    logic [CW-1:0]  pc_r;
    logic [CW-1:0]  pc_next_s;
    logic [RW-1:0]  run_r;
    logic [7:0]     rises_r;
    vote_state_t    state_r;

    logic           raw_s;
    logic           disagree_s;
    logic           toggle_s;
    logic           rise_s;

    popcount_tree #(.N(N)) u_popcount (
        .vec   (in_r),
        .count (pc_next_s)
    );

    // Two-stage input pipeline: capture the vector, then its popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_r <= {N{1'b0}};
            pc_r <= {CW{1'b0}};
        end else begin
            in_r <= i;
            pc_r <= pc_next_s;
        end
    end

    // Window decision and filter control; lo > hi naturally yields raw = 0.
    always_comb begin
        raw_s      = 1'b0;
        disagree_s = 1'b0;
        toggle_s   = 1'b0;
        rise_s     = 1'b0;
        if (en && (lo <= pc_r) && (pc_r <= hi)) begin
            raw_s = 1'b1;
        end else begin
            raw_s = 1'b0;
        end
        disagree_s = (raw_s != (state_r == ON));
        if (disagree_s && (run_r == RUN_LAST)) begin
            toggle_s = 1'b1;
        end else begin
            toggle_s = 1'b0;
        end
        if (toggle_s && (state_r == OFF)) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
    end

    // Filter FSM with its run counter and the saturating rising-edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= OFF;
            run_r   <= {RW{1'b0}};
            rises_r <= 8'd0;
        end else begin
            case (state_r)
                OFF: begin
                    if (toggle_s) state_r <= ON;
                    else          state_r <= OFF;
                end
                ON: begin
                    if (toggle_s) state_r <= OFF;
                    else          state_r <= ON;
                end
                default: state_r <= OFF;
            endcase

            // Any cycle of agreement, or a completed run, starts over.
            if (!disagree_s || toggle_s) begin
                run_r <= {RW{1'b0}};
            end else begin
                run_r <= run_r + RW'(1);
            end

            // A clear that coincides with a rise keeps that rise.
            if (clr) begin
                rises_r <= rise_s ? 8'd1 : 8'd0;
            end else if (rise_s && (rises_r != RISES_MAX)) begin
                rises_r <= rises_r + 8'd1;
            end else begin
                rises_r <= rises_r;
            end
        end
    end

    assign o     = (state_r == ON);
    assign cnt   = pc_r;
    assign rises = rises_r;

endmodule

// File: tb/tb_window_vote_filter.sv
// -----------------------------------------------------------------------------
// tb_window_vote_filter
// Drives two filters (STABLE=1 and STABLE=3) from the same inputs and compares
// them every cycle with a history-based reference model, plus directed checks
// of the latency and boundary behaviour.
// -----------------------------------------------------------------------------
module tb_window_vote_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i   = 4'd0;
    logic [2:0] lo  = 3'd0;
    logic [2:0] hi  = 3'd0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;

    logic       o1, o3;
    logic [2:0] cnt1, cnt3;
    logic [7:0] rises1, rises3;

    int errors = 0;
    int checks = 0;

    // Reference model state: index 0 is STABLE=1, index 1 is STABLE=3.
    logic [3:0] m_in  = 4'd0;
    int         m_pc  = 0;
    bit         m_o     [2];
    int         m_rises [2];
    bit [7:0]   m_hist  [2];
    int         m_len   [2];
    int         saved_rises;

    window_vote_filter #(.N(4), .STABLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i(i), .lo(lo), .hi(hi), .en(en), .clr(clr),
        .o(o1), .cnt(cnt1), .rises(rises1)
    );

    window_vote_filter #(.N(4), .STABLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .i(i), .lo(lo), .hi(hi), .en(en), .clr(clr),
        .o(o3), .cnt(cnt3), .rises(rises3)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("cnt_s1", {29'd0, cnt1}, m_pc);
        check("cnt_s3", {29'd0, cnt3}, m_pc);
        check("o_s1", {31'd0, o1}, {31'd0, m_o[0]});
        check("o_s3", {31'd0, o3}, {31'd0, m_o[1]});
        check("rises_s1", {24'd0, rises1}, m_rises[0]);
        check("rises_s3", {24'd0, rises3}, m_rises[1]);
    endtask

    // Advance the model with the inputs now applied, clock once, compare.
    // o flips once the last STABLE window decisions since the previous flip
    // (or reset) all disagree with it.
    task automatic step();
        bit raw, flip, rise;
        int st;
        if (rst) begin
            m_in = 4'd0;
            m_pc = 0;
            for (int d = 0; d < 2; d++) begin
                m_o[d] = 1'b0; m_rises[d] = 0; m_hist[d] = 8'd0; m_len[d] = 0;
            end
        end else begin
            raw = en && (int'(lo) <= m_pc) && (m_pc <= int'(hi));
            for (int d = 0; d < 2; d++) begin
                st = (d == 0) ? 1 : 3;
                m_hist[d] = {m_hist[d][6:0], raw};
                m_len[d]++;
                flip = 1'b0;
                if (m_len[d] >= st) begin
                    flip = 1'b1;
                    for (int b = 0; b < st; b++)
                        if (m_hist[d][b] == m_o[d]) flip = 1'b0;
                end
                rise = flip && !m_o[d];
                if (flip) begin
                    m_o[d] = !m_o[d];
                    m_len[d] = 0;
                end
                if (clr) m_rises[d] = rise ? 1 : 0;
                else if (rise && m_rises[d] < 255) m_rises[d]++;
            end
            m_pc = $countones(m_in);
            m_in = i;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_o[d] = 1'b0; m_rises[d] = 0; m_hist[d] = 8'd0; m_len[d] = 0;
        end
        #2;

        // Reset state.
        rst = 1'b1;
        step();
        step();
        check("reset_o", {31'd0, o3}, 32'd0);
        check("reset_cnt", {29'd0, cnt3}, 32'd0);
        check("reset_rises", {24'd0, rises3}, 32'd0);
        rst = 1'b0;

        // Legacy equivalence sweep: 2-or-3-of-4 on the STABLE=1 instance.
        lo = 3'd2; hi = 3'd3; en = 1'b1;
        for (int v = 0; v < 16; v++) begin
            i = 4'(v);
            for (int h = 0; h < 4; h++) begin
                step();
                if (h >= 1) check("legacy_cnt", {29'd0, cnt1}, $countones(4'(v)));
                if (h >= 2) check("legacy_o", {31'd0, o1},
                                  ($countones(4'(v)) inside {2, 3}) ? 32'd1 : 32'd0);
            end
        end

        // Clear alone.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_alone_s3", {24'd0, rises3}, 32'd0);
        check("clr_alone_s1", {24'd0, rises1}, 32'd0);

        // Bounce rejection.
        i = 4'b0000;
        repeat (3) step();
        for (int t = 0; t < 10; t++) begin
            i = (t % 2 == 0) ? 4'b0011 : 4'b0000;
            step();
            check("bounce_hold_low", {31'd0, o3}, 32'd0);
        end
        i = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            step();
            check("bounce_early", {31'd0, o3}, 32'd0);
        end
        step();
        check("bounce_rise", {31'd0, o3}, 32'd1);
        check("bounce_rises", {24'd0, rises3}, 32'd1);

        // Window edge cases: lo = hi = N.
        lo = 3'd4; hi = 3'd4; i = 4'b1111;
        repeat (6) step();
        check("lohi4_s1", {31'd0, o1}, 32'd1);
        check("lohi4_s3", {31'd0, o3}, 32'd1);

        // Inverted window never matches.
        lo = 3'd3; hi = 3'd1;
        for (int t = 0; t < 8; t++) begin
            i = 4'($urandom);
            step();
        end
        check("inverted_s1", {31'd0, o1}, 32'd0);
        check("inverted_s3", {31'd0, o3}, 32'd0);

        // en=0 while ON.
        lo = 3'd0; hi = 3'd4; en = 1'b1;
        repeat (6) step();
        check("en_on", {31'd0, o3}, 32'd1);
        saved_rises = m_rises[1];
        en = 1'b0;
        step();
        step();
        check("en_off_hold", {31'd0, o3}, 32'd1);
        step();
        check("en_off_fall", {31'd0, o3}, 32'd0);
        check("en_off_rises", {24'd0, rises3}, saved_rises);

        // Saturation: 260 qualified rises.
        repeat (4) step();
        for (int r = 0; r < 260; r++) begin
            en = 1'b1;
            repeat (3) step();
            en = 1'b0;
            repeat (3) step();
        end
        check("sat_s3", {24'd0, rises3}, 32'd255);
        check("sat_s1", {24'd0, rises1}, 32'd255);

        // Clear coinciding with a rise, then clear alone.
        en = 1'b1;
        step();
        step();
        clr = 1'b1;
        step();
        check("clr_on_rise", {24'd0, rises3}, 32'd1);
        clr = 1'b0;
        en = 1'b0;
        repeat (4) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_after", {24'd0, rises3}, 32'd0);

        // Reset in the middle of a run.
        lo = 3'd2; hi = 3'd3; i = 4'b0011; en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        step();
        step();
        rst = 1'b1;
        clr = 1'b1;
        step();
        check("midrst_o", {31'd0, o3}, 32'd0);
        check("midrst_cnt", {29'd0, cnt3}, 32'd0);
        check("midrst_rises", {24'd0, rises3}, 32'd0);
        check("midrst_o_s1", {31'd0, o1}, 32'd0);
        rst = 1'b0;
        clr = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            check("midrst_early", {31'd0, o3}, 32'd0);
        end
        step();
        check("midrst_rise", {31'd0, o3}, 32'd1);
        check("midrst_rises1", {24'd0, rises3}, 32'd1);

        // Randomized phase against the model.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) i = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lo = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) hi = 3'($urandom_range(0, 5));
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_vote_filter.md
# window_vote_filter

Registered, parametrised successor to the fixed 2-or-3-of-4 detector. Counts the set bits of an N-bit input vector and flags when the count lies in a runtime window [lo, hi]. A stability filter makes the flag change only after the window decision has held for STABLE consecutive cycles, so the output is glitch-free and bounce-free by construction. A saturating counter records qualified rising edges. It sits between raw switch/sensor inputs and downstream control logic in the lab designs.

## Interface
- N, 4: input vector width; N ≥ 1.
- STABLE, 3: consecutive cycles the window decision must hold before `o` changes; STABLE ≥ 1.
- CW, derived, $clog2(N+1): width of the count and the thresholds.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i  in  N  raw input vector; may change at any time relative to clk, but must be synchronous to clk.
- lo  in  CW  lower window bound, inclusive.
- hi  in  CW  upper window bound, inclusive.
- en  in  1  window enable; when 0 the raw decision is forced to 0.
- clr  in  1  clears `rises`.
- o  out  1  filtered window flag.
- cnt  out  CW  registered popcount of the input.
- rises  out  8  saturating count of `o` 0→1 transitions.

## Operation
- **Stage 1:** `in_q <= i`.
- **Stage 2:** `pc_q <= popcount(in_q)`; drive `cnt = pc_q`.
- **Raw decision (combinational):** `raw = en && (lo <= pc_q) && (pc_q <= hi)`.
  - Compare unsigned at width CW.
  - If lo > hi, `raw` is never 1.
  - `lo`, `hi` and `en` are not registered; changes take effect on the next edge.
- **Filter:** 2-state FSM, OFF (`o = 0`) and ON (`o = 1`), plus run counter `run_q` of width $clog2(STABLE+1).
  - raw == o: `run_q <= 0`.
  - raw != o and run_q < STABLE−1: `run_q <= run_q + 1`.
  - raw != o and run_q == STABLE−1: toggle state, `run_q <= 0`.
  - Any single-cycle agreement with `o` restarts the run.
  - STABLE = 1 degenerates to `o` following `raw` one cycle late.
- **Rises counter:** on each OFF→ON transition, `rises` increments and saturates at 255.
  - clr alone: `rises <= 0`.
  - clr and OFF→ON in the same cycle: `rises <= 1`.
  - ON→OFF does not affect `rises`.
- **Reset:** `in_q`, `pc_q`, `run_q`, `rises` = 0; state = OFF.
  - Outputs after reset: `o` = 0, `cnt` = 0, `rises` = 0.
  - A reset mid-run discards any partial run.
  - While rst is high, `clr`, `en`, `i` are ignored.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `cnt` reflects `i` sampled at edge k after edge k+1.
- `o` change latency:
  - A change of `i` sampled at edge k that flips `raw` moves `o` after edge k+1+STABLE, provided `raw` holds.
  - A `lo`/`hi`/`en` change applied before edge m moves `o` after edge m+STABLE−1.
- `rises` updates on the same edge as `o` rises.
- First valid `cnt` after reset release: 2 edges. `o` cannot rise earlier than STABLE+2 edges after reset release.

## Structure
- Package `window_vote_pkg`:
  - function `clog2p1(n)` for CW;
  - `typedef enum logic {OFF, ON} vote_state_t`;
  - localparam `RISES_MAX = 8'd255`.
- Sub-module `popcount_tree #(N)`: combinational adder tree, output CW bits.
  - Instantiated once between stage 1 and stage 2.
  - Reused elsewhere in the lab.
- Top module: pipeline registers, comparator, FSM, run counter, rises counter.

## Test plan
- **Legacy equivalence.** N=4, lo=2, hi=3, en=1, STABLE=1; sweep all 16 values of `i`, each held 4 cycles.
  - Required: `o` = 1 exactly for popcounts 2 and 3 (e.g. 0011, 0111 → 1; 0001, 1111 → 0), 3 edges after sampling.
  - Required: `cnt` matches popcount after 2 edges.
- **Bounce rejection.** STABLE=3; `i` toggles 0000↔0011 every cycle for 10 cycles, then holds 0011.
  - Required: `o` stays 0 during toggling and rises exactly 5 edges after the first 0011 of the hold.
  - Required: `rises` = 1.
- **Window edge cases.**
  - lo=hi=4, i=1111 → `o` = 1.
  - lo=3, hi=1 with any `i` → `o` = 0.
  - en=0 while ON → `o` falls after STABLE edges, `rises` unchanged.
- **Saturation and clear.** Generate 260 qualified rises → `rises` = 255. Then clr on the cycle of a rise → `rises` = 1. Then clr alone → `rises` = 0.
- **Reset mid-run.** STABLE=3; window condition true for 2 cycles, then rst for 1 cycle while the condition stays true.
  - Required: `o`, `cnt`, `rises` = 0 after the reset edge.
  - Required: `o` rises 5 edges after reset release (2 pipeline edges + 3 filter edges).
